// File: rtl/midi_gate_ctrl.sv
// Monophonic MIDI note front end: channel-filtered parser, last-note-priority stack, gate pulses.
// Optional macro MIDI_ALL_NOTES_OFF_EN enables CC 123 (All Notes Off) handling.
module midi_gate_ctrl #(
    parameter logic [3:0] MIDI_CHANNEL = 4'd0,
    parameter int         STACK_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] midi_byte,
    input  logic       midi_dv,
    output logic       gate_on,
    output logic       gate_off,
    output logic       gate,
    output logic [6:0] note,
    output logic [6:0] velocity
);
    localparam int CW = $clog2(STACK_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_D1, S_WAIT_D2} state_t;

    state_t      r_state, w_state_next;
    logic [3:0]  r_type, r_chan;
    logic [6:0]  r_d1;
    logic [6:0]  r_stack [STACK_DEPTH];
    logic [CW-1:0] r_count;
    logic        r_gate_on, r_gate_off, r_gate;
    logic [6:0]  r_note, r_velocity;

    logic        w_complete, w_latch_status, w_clear_status, w_latch_d1;
    logic        w_for_us, w_note_on, w_note_off, w_all_off;

    // Parser: realtime bytes fall through with no effect on any state.
    always_comb begin
        w_state_next   = r_state;
        w_complete     = 1'b0;
        w_latch_status = 1'b0;
        w_clear_status = 1'b0;
        w_latch_d1     = 1'b0;
        if (midi_dv) begin
            if (midi_byte >= 8'hF8) begin
                w_state_next = r_state;
            end else if (midi_byte >= 8'hF0) begin
                w_clear_status = 1'b1;
                w_state_next   = S_IDLE;
            end else if (midi_byte[7]) begin
                w_latch_status = 1'b1;
                w_state_next   = S_WAIT_D1;
            end else begin
                case (r_state)
                    S_WAIT_D1: begin
                        if (r_type != 4'hC && r_type != 4'hD) begin
                            w_latch_d1   = 1'b1;
                            w_state_next = S_WAIT_D2;
                        end
                    end
                    S_WAIT_D2: begin
                        w_complete   = 1'b1;
                        w_state_next = S_WAIT_D1;
                    end
                    default: w_state_next = r_state;
                endcase
            end
        end
    end

    assign w_for_us   = w_complete && (r_chan == MIDI_CHANNEL);
    assign w_note_on  = w_for_us && (r_type == 4'h9) && (midi_byte[6:0] != 7'd0);
    assign w_note_off = w_for_us && ((r_type == 4'h8) ||
                                     ((r_type == 4'h9) && (midi_byte[6:0] == 7'd0)));
`ifdef MIDI_ALL_NOTES_OFF_EN
    assign w_all_off  = w_for_us && (r_type == 4'hB) && (r_d1 == 7'h7B);
`else
    assign w_all_off  = 1'b0;
`endif

    // Stack: index 0 is the oldest entry, r_count-1 is the top.
    logic [STACK_DEPTH-1:0] w_match;
    logic          w_hit, w_top_hit, w_full;
    logic [CW-1:0] w_pos, w_rm_count, w_on_count, w_push_idx;
    logic [6:0]    w_rm [STACK_DEPTH];
    logic [6:0]    w_on [STACK_DEPTH];
    logic [6:0]    w_new_top;

    always_comb begin
        w_pos = '0;
        for (int i = STACK_DEPTH - 1; i >= 0; i--) begin
            if (w_match[i]) w_pos = CW'(i);
        end
    end

    assign w_hit      = |w_match;
    assign w_top_hit  = w_hit && (w_pos == r_count - CW'(1));
    assign w_rm_count = w_hit ? r_count - CW'(1) : r_count;
    assign w_full     = (w_rm_count == CW'(STACK_DEPTH));
    assign w_push_idx = w_full ? CW'(STACK_DEPTH - 1) : w_rm_count;
    assign w_on_count = w_full ? w_rm_count : w_rm_count + CW'(1);
    assign w_new_top  = w_rm[w_rm_count - CW'(1)];

    genvar gi;
    generate
        for (gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
            assign w_match[gi] = (CW'(gi) < r_count) && (r_stack[gi] == r_d1);
            if (gi == STACK_DEPTH - 1) begin : g_last
                assign w_rm[gi] = r_stack[gi];
                assign w_on[gi] = (CW'(gi) == w_push_idx) ? r_d1 : w_rm[gi];
            end else begin : g_mid
                assign w_rm[gi] = (w_hit && CW'(gi) >= w_pos) ? r_stack[gi+1] : r_stack[gi];
                assign w_on[gi] = (CW'(gi) == w_push_idx) ? r_d1
                                : (w_full ? w_rm[gi+1] : w_rm[gi]);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_type     <= '0;
            r_chan     <= '0;
            r_d1       <= '0;
            r_count    <= '0;
            r_gate_on  <= 1'b0;
            r_gate_off <= 1'b0;
            r_gate     <= 1'b0;
            r_note     <= '0;
            r_velocity <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
        end else begin
            r_state    <= w_state_next;
            r_gate_on  <= 1'b0;
            r_gate_off <= 1'b0;
            if (w_latch_status) begin
                r_type <= midi_byte[7:4];
                r_chan <= midi_byte[3:0];
            end else if (w_clear_status) begin
                r_type <= '0;
                r_chan <= '0;
            end
            if (w_latch_d1) r_d1 <= midi_byte[6:0];

            if (w_note_on) begin
                for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= w_on[i];
                r_count    <= w_on_count;
                r_note     <= r_d1;
                r_velocity <= midi_byte[6:0];
                r_gate_on  <= 1'b1;
                r_gate     <= 1'b1;
            end else if (w_note_off && w_hit) begin
                for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= w_rm[i];
                r_count <= w_rm_count;
                if (w_top_hit) begin
                    if (w_rm_count != '0) begin
                        r_note    <= w_new_top;
                        r_gate_on <= 1'b1;
                    end else begin
                        r_gate_off <= 1'b1;
                        r_gate     <= 1'b0;
                    end
                end
            end else if (w_all_off) begin
                r_count    <= '0;
                r_gate_off <= r_gate;
                r_gate     <= 1'b0;
            end
        end
    end

    assign gate_on  = r_gate_on;
    assign gate_off = r_gate_off;
    assign gate     = r_gate;
    assign note     = r_note;
    assign velocity = r_velocity;
endmodule

// File: tb/tb_midi_gate_ctrl.sv
// Bench for midi_gate_ctrl: directed and random MIDI byte streams, queue scoreboard
// fed by a message-level reference model and drained by an output monitor.
module tb_midi_gate_ctrl;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] midi_byte;
    logic       midi_dv;
    logic       gate_on, gate_off, gate;
    logic [6:0] note, velocity;

    midi_gate_ctrl #(.MIDI_CHANNEL(4'd0), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .midi_byte(midi_byte), .midi_dv(midi_dv),
        .gate_on(gate_on), .gate_off(gate_off), .gate(gate),
        .note(note), .velocity(velocity)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit     on;
        int     note;
        int     vel;
        int     gate;
        longint cyc;
    } exp_t;

    exp_t   sb[$];
    longint cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;

    // Reference model state (message level)
    int m_rs = -1;
    bit m_have_d1 = 0;
    int m_d1 = 0;
    int m_stack[$];
    int m_note = 0, m_vel = 0, m_gate = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint act, input longint exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: pops and compares whenever the DUT pulses; flags missing pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (gate_on && gate_off) chk("pulse_exclusive", 1, 0);
            if (gate_on || gate_off) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", gate_on ? 1 : 2, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pulse_cycle", cyc, e.cyc);
                    chk("pulse_kind_on", gate_on, e.on);
                    chk("note", note, e.note);
                    chk("velocity", velocity, e.vel);
                    chk("gate", gate, e.gate);
                    $display("pulse %s note=%0d vel=%0d gate=%0d cyc=%0d",
                             gate_on ? "ON " : "OFF", note, velocity, gate, cyc);
                end
            end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                chk("missing_pulse", 0, 1);
                void'(sb.pop_front());
            end
        end
    end

    function automatic int find_note(input int n);
        for (int i = 0; i < m_stack.size(); i++) if (m_stack[i] == n) return i;
        return -1;
    endfunction

    task automatic push_exp(input bit on, input longint at);
        exp_t e;
        e.on = on; e.note = m_note; e.vel = m_vel; e.gate = m_gate; e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic model_message(input int typ, input int ch, input int d1, input int d2,
                                 input longint at);
        int idx;
        if (ch != 0) return;
        if (typ == 9 && d2 != 0) begin
            idx = find_note(d1);
            if (idx >= 0) m_stack.delete(idx);
            if (m_stack.size() == DEPTH) m_stack.delete(0);
            m_stack.push_back(d1);
            m_note = d1; m_vel = d2; m_gate = 1;
            push_exp(1, at);
        end else if (typ == 8 || typ == 9) begin
            idx = find_note(d1);
            if (idx < 0) return;
            if (idx == m_stack.size() - 1) begin
                m_stack.delete(idx);
                if (m_stack.size() > 0) begin
                    m_note = m_stack[m_stack.size() - 1];
                    push_exp(1, at);
                end else begin
                    m_gate = 0;
                    push_exp(0, at);
                end
            end else begin
                m_stack.delete(idx);
            end
        end
`ifdef MIDI_ALL_NOTES_OFF_EN
        else if (typ == 11 && d1 == 123) begin
            m_stack.delete();
            if (m_gate == 1) begin
                m_gate = 0;
                push_exp(0, at);
            end
        end
`endif
    endtask

    task automatic model_byte(input int b, input longint at);
        int typ;
        if (b >= 'hF8) return;
        if (b >= 'hF0) begin m_rs = -1; m_have_d1 = 0; return; end
        if (b >= 'h80) begin m_rs = b; m_have_d1 = 0; return; end
        if (m_rs < 0) return;
        typ = m_rs >> 4;
        if (typ == 'hC || typ == 'hD) return;
        if (!m_have_d1) begin
            m_d1 = b; m_have_d1 = 1;
        end else begin
            m_have_d1 = 0;
            model_message(typ, m_rs & 15, m_d1, b, at);
        end
    endtask

    task automatic send(input int b);
        @(negedge clk);
        midi_byte = 8'(b);
        midi_dv = 1'b1;
        model_byte(b, cyc + 1);
        @(posedge clk);
        #1;
        midi_dv = 1'b0;
        midi_byte = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        idle(3);
        chk({tag, "_gate"}, gate, m_gate);
        chk({tag, "_note"}, note, m_note);
        chk({tag, "_vel"}, velocity, m_vel);
        chk({tag, "_sb_empty"}, sb.size(), 0);
        $display("state %s: gate=%0d note=%0d vel=%0d", tag, gate, note, velocity);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        midi_dv = 1'b0;
        idle(2);
        sb.delete();
        m_rs = -1; m_have_d1 = 0; m_stack.delete();
        m_note = 0; m_vel = 0; m_gate = 0;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, b;
        rst = 1'b1; midi_dv = 1'b0; midi_byte = 8'h00;
        idle(3);
        rst = 1'b0;
        idle(1);
        chk("reset_gate_on", gate_on, 0);
        chk("reset_gate_off", gate_off, 0);
        check_state("reset");

        send('h90); send('h3C); send('h64);
        check_state("on60");
        send('h80); send('h3C); send('h00);
        check_state("off60");

        send('h90); send('h3C); send('h40); send('h3E); send('h50);
        check_state("running");
        send('h3E); send('h00);
        check_state("vel0off");
        send('h3C); send('h00);
        check_state("clear1");

        for (int n = 60; n <= 64; n++) begin send('h90); send(n); send('h64); end
        check_state("overflow");
        for (int n = 64; n >= 60; n--) begin send('h80); send(n); send('h00); end
        check_state("offs");

        send('h91); send('h3C); send('h64);
        check_state("chan1");
        send('h90); send('h3C); send('hF8); send('h64);
        check_state("realtime");
        send('h80); send('h3C); send('h00);
        send('h90); send('h3C); send('hF0); send('h64);
        check_state("sysex");

        send('h90); send(60); send(70); send(64); send(71);
        send('h80); send(60); send(0);
        check_state("nontop");
        send(64); send(0);
        check_state("nontop_off");

        send('h90); send('h3C);
        do_reset();
        send('h64);
        check_state("midreset");

        send('h90); send(60); send(90); send(62); send(91);
        send('hB0); send('h7B); send('h00);
        check_state("allnotesoff");
        send('h80); send(62); send(0); send(60); send(0);
        check_state("cleanup");

        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(0, 99);
            if (r < 5)       b = 'hF8 + $urandom_range(0, 7);
            else if (r < 7)  b = 'hF0 + $urandom_range(0, 7);
            else if (r < 22) begin
                case ($urandom_range(0, 5))
                    0: b = 'h80; 1, 2: b = 'h90; 3: b = 'hB0; 4: b = 'hC0;
                    default: b = 'hE0;
                endcase
                if ($urandom_range(0, 9) == 0) b = b | $urandom_range(1, 15);
            end else begin
                case ($urandom_range(0, 5))
                    0: b = 0;
                    1: b = 'h7B;
                    2: b = $urandom_range(0, 127);
                    default: b = 58 + $urandom_range(0, 8);
                endcase
            end
            send(b);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        check_state("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
